// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: frame_sync-aligned, outputs all four channels at once.
// Optional TDM_DEMUX4_SYNC_CHECK_EN drops lock when frame_sync is missing at slot 0.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  // Next-state: slot 3 is never shadowed, it goes straight from din to d.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    sh2_d         = sh2_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (en) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          sh0_d   = din;
          sel_d   = 2'd1;
          state_d = LOCKED;
        end
      end else if (frame_sync && (sel_q != 2'd0)) begin
        sync_err_d = 1'b1;
        sh0_d      = din;
        sel_d      = 2'd1;
      end
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
      else if (!frame_sync && (sel_q == 2'd0)) begin
        sync_err_d = 1'b1;
        state_d    = HUNT;
      end
`endif
      else begin
        unique case (sel_q)
          2'd0: sh0_d = din;
          2'd1: sh1_d = din;
          2'd2: sh2_d = din;
          default: begin
            a_d           = sh0_q;
            b_d           = sh1_q;
            c_d           = sh2_q;
            d_d           = din;
            frame_valid_d = 1'b1;
          end
        endcase
        sel_d = sel_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      sel_q         <= 2'd0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign sel         = sel_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: vector table, directed corner cases, and
// randomized traffic against a queue-based frame model. Honours TDM_DEMUX4_SYNC_CHECK_EN.
module tb_tdm_demux4;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst, en, fs;
  logic [W-1:0] din;
  logic [0:0]   din_n;
  logic [W-1:0] a_w, b_w, c_w, d_w;
  logic [0:0]   a_n, b_n, c_n, d_n;
  logic [1:0]   sel_w, sel_n;
  logic         fv_w, lk_w, se_w, fv_n, lk_n, se_n;

  int n_tests = 0;
  int n_fail  = 0;

  assign din_n = din[0];
  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(W)) u_wide (
    .clk(clk), .rst(rst), .en(en), .din(din), .frame_sync(fs),
    .a(a_w), .b(b_w), .c(c_w), .d(d_w), .sel(sel_w),
    .frame_valid(fv_w), .locked(lk_w), .sync_err(se_w));

  tdm_demux4 #(.WIDTH(1)) u_narrow (
    .clk(clk), .rst(rst), .en(en), .din(din_n), .frame_sync(fs),
    .a(a_n), .b(b_n), .c(c_n), .d(d_n), .sel(sel_n),
    .frame_valid(fv_n), .locked(lk_n), .sync_err(se_n));

  // Reference model: samples collected since the last frame_sync, in order.
  logic [W-1:0] q_m[$];
  logic [W-1:0] a_m, b_m, c_m, d_m;
  logic         lk_m, fv_m, se_m;
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
  localparam bit SYNC_CHECK = 1'b1;
`else
  localparam bit SYNC_CHECK = 1'b0;
`endif

  task automatic model_reset();
    q_m.delete();
    lk_m = 1'b0; fv_m = 1'b0; se_m = 1'b0;
    a_m = '0; b_m = '0; c_m = '0; d_m = '0;
  endtask

  task automatic model_edge(input logic e, input logic f, input logic [W-1:0] x);
    fv_m = 1'b0;
    se_m = 1'b0;
    if (!e) return;
    if (!lk_m) begin
      if (f) begin q_m.delete(); q_m.push_back(x); lk_m = 1'b1; end
    end else if (f && q_m.size() != 0) begin
      se_m = 1'b1;
      q_m.delete();
      q_m.push_back(x);
    end else if (!f && q_m.size() == 0 && SYNC_CHECK) begin
      se_m = 1'b1;
      lk_m = 1'b0;
    end else begin
      q_m.push_back(x);
      if (q_m.size() == 4) begin
        a_m = q_m[0]; b_m = q_m[1]; c_m = q_m[2]; d_m = q_m[3];
        fv_m = 1'b1;
        q_m.delete();
      end
    end
  endtask

  function automatic logic [20:0] got_w();
    return {a_w, b_w, c_w, d_w, fv_w, lk_w, se_w, sel_w};
  endfunction

  function automatic logic [8:0] got_n();
    return {a_n, b_n, c_n, d_n, fv_n, lk_n, se_n, sel_n};
  endfunction

  function automatic logic [20:0] exp_w();
    return {a_m, b_m, c_m, d_m, fv_m, lk_m, se_m, 2'(q_m.size())};
  endfunction

  function automatic logic [8:0] exp_n();
    return {a_m[0], b_m[0], c_m[0], d_m[0], fv_m, lk_m, se_m, 2'(q_m.size())};
  endfunction

  task automatic chk(input string name, input logic [20:0] got, input logic [20:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (a,b,c,d,fv,lk,se,sel)", name, got, exp);
    end
  endtask

  task automatic chk_n(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (narrow a,b,c,d,fv,lk,se,sel)", name, got, exp);
    end
  endtask

  // One clock with current inputs, model advanced and both DUTs compared.
  task automatic tick(input string name);
    @(posedge clk);
    #1;
    model_edge(en, fs, din);
    chk(name, got_w(), exp_w());
    chk_n({name, "_n"}, got_n(), exp_n());
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; fs = 1'b0; din = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive(input logic e, input logic f, input logic [W-1:0] x);
    en = e; fs = f; din = x;
  endtask

  typedef struct {
    logic e, f; logic [W-1:0] x;
    logic [W-1:0] ea, eb, ec, ed;
    logic efv, elk, ese; logic [1:0] esel;
  } vec_t;
  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1] = '{1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[2] = '{1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[3] = '{1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd3};
    tbl[4] = '{1'b1, 1'b0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[5] = '{1'b1, 1'b1, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[6] = '{1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[7] = '{1'b1, 1'b0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 2'd3};
    tbl[8] = '{1'b1, 1'b0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 2'd0};

    rst = 1'b1; en = 1'b0; fs = 1'b0; din = '0;
    #2;
    chk("reset_state", got_w(), 21'd0);
    chk_n("reset_state_n", got_n(), 9'd0);
    do_reset();

    // Discarded hunt sample, basic frame, then back-to-back frame.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].e, tbl[i].f, tbl[i].x);
      @(posedge clk);
      #1;
      chk($sformatf("table_%0d", i), got_w(),
          {tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ed, tbl[i].efv, tbl[i].elk, tbl[i].ese, tbl[i].esel});
      chk_n($sformatf("table_%0d_n", i), got_n(),
          {tbl[i].ea[0], tbl[i].eb[0], tbl[i].ec[0], tbl[i].ed[0], tbl[i].efv, tbl[i].elk, tbl[i].ese, tbl[i].esel});
    end

    // en gaps: three idle cycles (with a stray frame_sync) between slots 1 and 2.
    do_reset();
    drive(1, 1, 4'd0); tick("gap_s0");
    drive(1, 0, 4'd1); tick("gap_s1");
    for (int i = 0; i < 3; i++) begin drive(0, i == 1, 4'hf); tick("gap_idle"); end
    drive(1, 0, 4'd0); tick("gap_s2");
    drive(1, 0, 4'd1); tick("gap_s3");
    chk("gap_frame", got_w(), {4'd0, 4'd1, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 2'd0});

    // Early sync at sel=2 restarts the frame without touching a..d.
    drive(1, 1, 4'd5); tick("early_s0");
    drive(1, 0, 4'd6); tick("early_s1");
    drive(1, 1, 4'd7); tick("early_sync");
    chk("early_sync_err", got_w(), {4'd0, 4'd1, 4'd0, 4'd1, 1'b0, 1'b1, 1'b1, 2'd1});
    for (int i = 8; i <= 10; i++) begin drive(1, 0, W'(i)); tick("early_next"); end
    chk("early_new_frame", got_w(), {4'd7, 4'd8, 4'd9, 4'd10, 1'b1, 1'b1, 1'b0, 2'd0});

    // Async reset between edges after slot 1, then an unsynchronised frame.
    drive(1, 1, 4'd3); tick("rst_s0");
    drive(1, 0, 4'd4); tick("rst_s1");
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", got_w(), 21'd0);
    chk_n("async_reset_n", got_n(), 9'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(1, 0, W'(i + 11)); tick("post_rst_nosync"); end
    chk("post_rst_idle", got_w(), 21'd0);

    // Second frame without frame_sync: build-dependent behaviour.
    do_reset();
    for (int i = 1; i <= 4; i++) begin drive(1, i == 1, W'(i)); tick("mac_f1"); end
    drive(1, 0, 4'd5); tick("mac_f2_s0");
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
    chk("mac_lost_sync", got_w(), {4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 2'd0});
`else
    chk("mac_free_run", got_w(), {4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1, 1'b0, 2'd1});
`endif
    for (int i = 6; i <= 8; i++) begin drive(1, 0, W'(i)); tick("mac_f2"); end
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
    chk("mac_no_frame", got_w(), {4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 2'd0});
`else
    chk("mac_second_frame", got_w(), {4'd5, 4'd6, 4'd7, 4'd8, 1'b1, 1'b1, 1'b0, 2'd0});
`endif

    // Randomized traffic with occasional asynchronous reset pulses.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 10) < 7, ($urandom % 100) < 18, W'($urandom));
      if (($urandom % 250) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
      end
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
